rgmii_rx_decoder: RTL and testbench

Receive-side RGMII decode stage that consumes the rising/falling-edge nibble pairs from the source-synchronous DDR input stage and produces a GMII-style byte stream for the MAC. It runs in the recovered RX clock domain, the same clock the DDR input stage exports to logic. The block pairs nibbles in 10/100 mode, decodes RX_DV/RX_ER from the RGMII control encoding, detects false carrier, and extracts filtered in-band link status from inter-frame periods.

---
 rtl/rgmii_rx_decoder.sv | 176 +++++++++++++++++
 tb/tb_rgmii_rx_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_decoder.sv
// RGMII receive decode stage: turns rising/falling-edge nibble pairs into a
// GMII-style byte stream with a byte strobe. Pairs nibbles in 10/100 mode,
// flags false carrier and filters in-band link status seen between frames.
module rgmii_rx_decoder #(
  parameter int unsigned INBAND_FILTER = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rxd_q1,
  input  logic [3:0] rxd_q2,
  input  logic       rx_ctl_q1,
  input  logic       rx_ctl_q2,
  input  logic       speed_1g,
  output logic [7:0] gmii_rxd,
  output logic       gmii_rx_dv,
  output logic       gmii_rx_er,
  output logic       gmii_rx_valid,
  output logic       false_carrier,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
);

  localparam int unsigned CntW = $clog2(INBAND_FILTER + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(INBAND_FILTER);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic {StLow, StHigh} state_e;

  state_e          state_q, state_d;
  logic [3:0]      low_q, low_d;
  logic            err_acc_q, err_acc_d;
  logic            idle_ph_q, idle_ph_d;
  logic            mode_q, mode_d;
  logic [7:0]      rxd_q, rxd_d;
  logic            rx_dv_q, rx_dv_d;
  logic            rx_er_q, rx_er_d;
  logic            valid_q, valid_d;
  logic            fc_q, fc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      cand_q, cand_d;
  logic            link_q, link_d;
  logic [1:0]      speed_q, speed_d;
  logic            dup_q, dup_d;

  logic dv, er;

  // Control decode, mode latch, nibble pairing FSM and false-carrier detect.
  always_comb begin
    dv = rx_ctl_q1;
    er = rx_ctl_q1 ^ rx_ctl_q2;

    // Mode only follows speed_1g outside frames; the loading cycle uses the new mode.
    mode_d = dv ? mode_q : speed_1g;

    state_d   = state_q;
    low_d     = low_q;
    err_acc_d = err_acc_q;
    idle_ph_d = 1'b0;
    rxd_d     = 8'h00;
    rx_dv_d   = 1'b0;
    rx_er_d   = 1'b0;
    valid_d   = 1'b0;

    if (mode_d) begin
      rxd_d   = {rxd_q2, rxd_q1};
      rx_dv_d = dv;
      rx_er_d = er;
      valid_d = 1'b1;
      // Any half-byte held from nibble mode is dropped on a switch to gigabit.
      state_d = StLow;
    end else begin
      unique case (state_q)
        StLow: begin
          if (dv) begin
            low_d     = rxd_q1;
            err_acc_d = er;
            state_d   = StHigh;
          end else begin
            // Idle strobe keeps the MAC clock enable at half rate between frames.
            valid_d   = idle_ph_q;
            idle_ph_d = ~idle_ph_q;
            rx_er_d   = er;
          end
        end
        StHigh: begin
          state_d = StLow;
          valid_d = 1'b1;
          rx_dv_d = 1'b1;
          if (dv) begin
            rxd_d   = {rxd_q1, low_q};
            rx_er_d = err_acc_q | er;
          end else begin
            // Frame ended on an odd nibble: flush it as an errored byte.
            rxd_d   = {4'h0, low_q};
            rx_er_d = 1'b1;
          end
        end
        default: state_d = StLow;
      endcase
    end

    fc_d = ~dv & er & (rxd_q1 == 4'hE);
  end

  // In-band status filter: a candidate must repeat INBAND_FILTER times in a row.
  always_comb begin
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    link_d  = link_q;
    speed_d = speed_q;
    dup_d   = dup_q;
    if (!rx_ctl_q1 && !rx_ctl_q2) begin
      cand_d = rxd_q1;
      if ((cnt_q != '0) && (rxd_q1 == cand_q)) begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
      end else begin
        cnt_d = CntOne;
      end
      if (cnt_d == CntMax) begin
        dup_d   = rxd_q1[3];
        speed_d = rxd_q1[2:1];
        link_d  = rxd_q1[0];
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLow;
      low_q     <= 4'h0;
      err_acc_q <= 1'b0;
      idle_ph_q <= 1'b0;
      mode_q    <= 1'b1;
      rxd_q     <= 8'h00;
      rx_dv_q   <= 1'b0;
      rx_er_q   <= 1'b0;
      valid_q   <= 1'b0;
      fc_q      <= 1'b0;
      cnt_q     <= '0;
      cand_q    <= 4'h0;
      link_q    <= 1'b0;
      speed_q   <= 2'b00;
      dup_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      low_q     <= low_d;
      err_acc_q <= err_acc_d;
      idle_ph_q <= idle_ph_d;
      mode_q    <= mode_d;
      rxd_q     <= rxd_d;
      rx_dv_q   <= rx_dv_d;
      rx_er_q   <= rx_er_d;
      valid_q   <= valid_d;
      fc_q      <= fc_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      link_q    <= link_d;
      speed_q   <= speed_d;
      dup_q     <= dup_d;
    end
  end

  assign gmii_rxd      = rxd_q;
  assign gmii_rx_dv    = rx_dv_q;
  assign gmii_rx_er    = rx_er_q;
  assign gmii_rx_valid = valid_q;
  assign false_carrier = fc_q;
  assign link_up       = link_q;
  assign link_speed    = speed_q;
  assign full_duplex   = dup_q;

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Directed bench for rgmii_rx_decoder: each record holds one cycle of inputs
// and the outputs required one clock later.
module tb_rgmii_rx_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] rxd_q1, rxd_q2;
  logic       rx_ctl_q1, rx_ctl_q2;
  logic       speed_1g;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv, gmii_rx_er, gmii_rx_valid;
  logic       false_carrier, link_up, full_duplex;
  logic [1:0] link_speed;

  int checks = 0;
  int errors = 0;

  rgmii_rx_decoder #(.INBAND_FILTER(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd_q1        (rxd_q1),
    .rxd_q2        (rxd_q2),
    .rx_ctl_q1     (rx_ctl_q1),
    .rx_ctl_q2     (rx_ctl_q2),
    .speed_1g      (speed_1g),
    .gmii_rxd      (gmii_rxd),
    .gmii_rx_dv    (gmii_rx_dv),
    .gmii_rx_er    (gmii_rx_er),
    .gmii_rx_valid (gmii_rx_valid),
    .false_carrier (false_carrier),
    .link_up       (link_up),
    .link_speed    (link_speed),
    .full_duplex   (full_duplex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       spd;
    logic [1:0] ctl;   // {rx_ctl_q1, rx_ctl_q2}
    logic [3:0] q2;
    logic [3:0] q1;
    logic       ev;    // expected gmii_rx_valid
    logic       edv;
    logic       eer;
    logic [7:0] erxd;
    logic       efc;
    logic [3:0] est;   // expected {full_duplex, link_speed, link_up}
  } vec_t;

  vec_t vq[$];

  localparam logic [3:0] S = 4'b1101;  // link up, 1G, full duplex

  function automatic vec_t mk(input logic r, input logic s, input logic [1:0] c,
                              input logic [3:0] q2, input logic [3:0] q1,
                              input logic ev, input logic edv, input logic eer,
                              input logic [7:0] erxd, input logic efc,
                              input logic [3:0] est);
    vec_t v;
    v.rst = r;   v.spd = s;   v.ctl = c;   v.q2 = q2;     v.q1 = q1;
    v.ev = ev;   v.edv = edv; v.eer = eer; v.erxd = erxd; v.efc = efc;
    v.est = est;
    return v;
  endfunction

  task automatic add(input logic r, input logic s, input logic [1:0] c,
                     input logic [3:0] q2, input logic [3:0] q1,
                     input logic ev, input logic edv, input logic eer,
                     input logic [7:0] erxd, input logic efc, input logic [3:0] est);
    vq.push_back(mk(r, s, c, q2, q1, ev, edv, eer, erxd, efc, est));
  endtask

  // Apply one cycle of inputs, then compare the registered outputs.
  // Data fields are only compared on cycles where a byte strobe is required.
  task automatic step(input vec_t v, input string tag);
    logic ok;
    rst       = v.rst;
    speed_1g  = v.spd;
    rx_ctl_q1 = v.ctl[1];
    rx_ctl_q2 = v.ctl[0];
    rxd_q2    = v.q2;
    rxd_q1    = v.q1;
    @(posedge clk);
    #1;
    ok = ({gmii_rx_valid, false_carrier, full_duplex, link_speed, link_up} ==
          {v.ev, v.efc, v.est});
    if (v.ev && ({gmii_rx_dv, gmii_rx_er, gmii_rxd} != {v.edv, v.eer, v.erxd})) ok = 1'b0;
    if (v.rst && ({gmii_rx_dv, gmii_rx_er, gmii_rxd} != 10'd0)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got valid=%b dv=%b er=%b rxd=%h fc=%b st=%b%b%b exp valid=%b dv=%b er=%b rxd=%h fc=%b st=%b",
               tag, gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd, false_carrier,
               full_duplex, link_speed, link_up, v.ev, v.edv, v.eer, v.erxd, v.efc, v.est);
    end
  endtask

  initial begin
    rst = 1'b1; speed_1g = 1'b1; rx_ctl_q1 = 1'b0; rx_ctl_q2 = 1'b0;
    rxd_q1 = 4'h0; rxd_q2 = 4'h0;

    // Reset state
    add(1, 1, 2'b00, 4'h0, 4'h0, 0, 0, 0, 8'h00, 0, 4'h0);
    add(1, 1, 2'b00, 4'h0, 4'h0, 0, 0, 0, 8'h00, 0, 4'h0);
    // Gigabit frame: preamble, SFD, data, then an errored byte
    add(0, 1, 2'b00, 4'h0, 4'h0, 1, 0, 0, 8'h00, 0, 4'h0);
    for (int i = 0; i < 7; i++) add(0, 1, 2'b11, 4'h5, 4'h5, 1, 1, 0, 8'h55, 0, 4'h0);
    add(0, 1, 2'b11, 4'hD, 4'h5, 1, 1, 0, 8'hD5, 0, 4'h0);
    add(0, 1, 2'b11, 4'h1, 4'h2, 1, 1, 0, 8'h12, 0, 4'h0);
    add(0, 1, 2'b11, 4'h3, 4'h4, 1, 1, 0, 8'h34, 0, 4'h0);
    add(0, 1, 2'b10, 4'h3, 4'h4, 1, 1, 1, 8'h34, 0, 4'h0);
    // False carrier, then error-only idle with a different nibble
    add(0, 1, 2'b01, 4'h0, 4'hE, 1, 0, 1, 8'h0E, 1, 4'h0);
    add(0, 1, 2'b01, 4'h0, 4'h5, 1, 0, 1, 8'h05, 0, 4'h0);
    add(0, 1, 2'b00, 4'h0, 4'h0, 1, 0, 0, 8'h00, 0, 4'h0);
    // In-band status: 3x D, one 0, then 4x D updates only after the last
    for (int i = 0; i < 3; i++) add(0, 1, 2'b00, 4'h0, 4'hD, 1, 0, 0, 8'h0D, 0, 4'h0);
    add(0, 1, 2'b00, 4'h0, 4'h0, 1, 0, 0, 8'h00, 0, 4'h0);
    for (int i = 0; i < 3; i++) add(0, 1, 2'b00, 4'h0, 4'hD, 1, 0, 0, 8'h0D, 0, 4'h0);
    add(0, 1, 2'b00, 4'h0, 4'hD, 1, 0, 0, 8'h0D, 0, S);
    add(0, 1, 2'b00, 4'h0, 4'hD, 1, 0, 0, 8'h0D, 0, S);
    // 10/100 idle: half-rate strobe
    add(0, 0, 2'b00, 4'h0, 4'hD, 0, 0, 0, 8'h00, 0, S);
    add(0, 0, 2'b00, 4'h0, 4'hD, 1, 0, 0, 8'h00, 0, S);
    add(0, 0, 2'b00, 4'h0, 4'hD, 0, 0, 0, 8'h00, 0, S);
    // 10/100 frame: 5,5,5,5,5,D,2,1 -> 55 55 D5 12
    for (int i = 0; i < 2; i++) begin
      add(0, 0, 2'b11, 4'h0, 4'h5, 0, 0, 0, 8'h00, 0, S);
      add(0, 0, 2'b11, 4'h0, 4'h5, 1, 1, 0, 8'h55, 0, S);
    end
    add(0, 0, 2'b11, 4'h0, 4'h5, 0, 0, 0, 8'h00, 0, S);
    add(0, 0, 2'b11, 4'h0, 4'hD, 1, 1, 0, 8'hD5, 0, S);
    add(0, 0, 2'b11, 4'h0, 4'h2, 0, 0, 0, 8'h00, 0, S);
    add(0, 0, 2'b11, 4'h0, 4'h1, 1, 1, 0, 8'h12, 0, S);
    // Odd-nibble end: 4,3,9 then idle -> 34, then 09 with er
    add(0, 0, 2'b11, 4'h0, 4'h4, 0, 0, 0, 8'h00, 0, S);
    add(0, 0, 2'b11, 4'h0, 4'h3, 1, 1, 0, 8'h34, 0, S);
    add(0, 0, 2'b11, 4'h0, 4'h9, 0, 0, 0, 8'h00, 0, S);
    add(0, 0, 2'b00, 4'h0, 4'hD, 1, 1, 1, 8'h09, 0, S);
    add(0, 0, 2'b00, 4'h0, 4'hD, 0, 0, 0, 8'h00, 0, S);
    add(0, 0, 2'b00, 4'h0, 4'hD, 1, 0, 0, 8'h00, 0, S);
    add(0, 0, 2'b00, 4'h0, 4'hD, 0, 0, 0, 8'h00, 0, S);
    // Error on the low nibble carries into the paired byte
    add(0, 0, 2'b10, 4'h0, 4'h7, 0, 0, 0, 8'h00, 0, S);
    add(0, 0, 2'b11, 4'h0, 4'h8, 1, 1, 1, 8'h87, 0, S);
    add(0, 0, 2'b00, 4'h0, 4'hD, 0, 0, 0, 8'h00, 0, S);
    // False carrier in nibble mode
    add(0, 0, 2'b01, 4'h0, 4'hE, 1, 0, 1, 8'h00, 1, S);
    add(0, 0, 2'b00, 4'h0, 4'hD, 0, 0, 0, 8'h00, 0, S);

    for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("vec%0d", i));

    // Reset after a held low nibble: nothing partial may come out
    step(mk(0, 0, 2'b11, 4'h0, 4'hA, 0, 0, 0, 8'h00, 0, S), "rst_pre");
    step(mk(1, 0, 2'b11, 4'h0, 4'hB, 0, 0, 0, 8'h00, 0, 4'h0), "rst_mid");
    step(mk(0, 0, 2'b00, 4'h0, 4'h0, 0, 0, 0, 8'h00, 0, 4'h0), "rst_post0");
    step(mk(0, 0, 2'b00, 4'h0, 4'h0, 1, 0, 0, 8'h00, 0, 4'h0), "rst_post1");

    // Speed toggled mid-frame takes effect only at the first idle cycle
    step(mk(0, 1, 2'b00, 4'h0, 4'h0, 1, 0, 0, 8'h00, 0, 4'h0), "spd_g_idle");
    step(mk(0, 1, 2'b11, 4'hA, 4'hB, 1, 1, 0, 8'hAB, 0, 4'h0), "spd_g_b0");
    step(mk(0, 0, 2'b11, 4'hC, 4'hD, 1, 1, 0, 8'hCD, 0, 4'h0), "spd_g_b1");
    step(mk(0, 0, 2'b11, 4'h1, 4'h2, 1, 1, 0, 8'h12, 0, 4'h0), "spd_g_b2");
    step(mk(0, 0, 2'b00, 4'h0, 4'h0, 0, 0, 0, 8'h00, 0, 4'h0), "spd_n_idle0");
    step(mk(0, 0, 2'b00, 4'h0, 4'h0, 1, 0, 0, 8'h00, 0, 4'h0), "spd_n_idle1");
    step(mk(0, 1, 2'b11, 4'h0, 4'h3, 0, 0, 0, 8'h00, 0, 4'h0), "spd_n_lo");
    step(mk(0, 1, 2'b11, 4'h0, 4'h4, 1, 1, 0, 8'h43, 0, 4'h0), "spd_n_hi");
    step(mk(0, 1, 2'b00, 4'h5, 4'h6, 1, 0, 0, 8'h56, 0, 4'h0), "spd_g_back");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
